cs_microsequencer: RTL and testbench



---
 rtl/cs_seq_pkg.sv | 39 +++
 rtl/cs_seq_stack.sv | 83 ++++++++
 rtl/cs_microsequencer.sv | 152 +++++++++++++++
 tb/tb_cs_microsequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cs_seq_pkg.sv
// -----------------------------------------------------------------------------
// cs_seq_pkg
// Shared definitions for the microprogram sequencer:
//   - sequencing op codes carried in the MIR COND field
//   - bit positions of {N,Z,V,C} inside the PSR
//   - builder for the opcode-dispatch control-store address
// -----------------------------------------------------------------------------
package cs_seq_pkg;

    // Sequencing op codes (11..15 are reserved and sequence like OP_NEXT)
    localparam logic [3:0] OP_NEXT   = 4'd0;
    localparam logic [3:0] OP_BRN    = 4'd1;
    localparam logic [3:0] OP_BRZ    = 4'd2;
    localparam logic [3:0] OP_BRV    = 4'd3;
    localparam logic [3:0] OP_BRC    = 4'd4;
    localparam logic [3:0] OP_BR13   = 4'd5;
    localparam logic [3:0] OP_JUMP   = 4'd6;
    localparam logic [3:0] OP_DECODE = 4'd7;
    localparam logic [3:0] OP_CALL   = 4'd8;
    localparam logic [3:0] OP_RET    = 4'd9;
    localparam logic [3:0] OP_WAIT   = 4'd10;

    // PSR bit positions, PSR = {N,Z,V,C}
    localparam int PSR_N = 3;
    localparam int PSR_Z = 2;
    localparam int PSR_V = 1;
    localparam int PSR_C = 0;

    // Natural width of a dispatch address before zero-extension to ADDR_W
    localparam int DISPATCH_W = 11;

    // Dispatch target: {1, op[1:0], op3[5:0], 00}. The leading 1 places every
    // dispatch entry in the upper half of the 2K base microprogram, and the
    // two low zeros give each instruction a 4-word slot.
    function automatic logic [DISPATCH_W-1:0] dispatch_addr(input logic [31:0] ir);
        return {1'b1, ir[31:30], ir[24:19], 2'b00};
    endfunction

endpackage

// File: rtl/cs_seq_stack.sv
// -----------------------------------------------------------------------------
// cs_seq_stack
// Micro-return LIFO used by CALL/RET.
// Ports:
//   clk    in   clock, all updates on the rising edge
//   rst_n  in   synchronous reset, active-low (empties the stack)
//   push   in   write din on top of the stack (ignored when full)
//   pop    in   discard the top entry (ignored when empty)
//   din    in   WIDTH  return address to push
//   top    out  WIDTH  current top entry (zero when empty)
//   sp     out  occupancy, 0..DEPTH
//   full   out  sp == DEPTH
//   empty  out  sp == 0
// -----------------------------------------------------------------------------
module cs_seq_stack #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0]     sp,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [SP_W-1:0]  sp_r;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_s    = (sp_r == SP_W'(DEPTH));
    assign empty_s   = (sp_r == {SP_W{1'b0}});
    assign do_push_s = push & ~full_s;
    assign do_pop_s  = pop & ~empty_s;
    // Next free slot is at sp, the live top is at sp-1; both are only used
    // when in range (guarded by full/empty), so truncation is safe.
    assign wr_idx_s  = IDX_W'(sp_r);
    assign rd_idx_s  = IDX_W'(sp_r - SP_W'(1));

    // Storage write; entries above sp are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        if (rst_n && do_push_s) begin
            mem_r[wr_idx_s] <= din;
        end
    end

    // Occupancy counter; push has priority, although callers never assert both
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_r <= {SP_W{1'b0}};
        end else if (do_push_s) begin
            sp_r <= sp_r + SP_W'(1);
        end else if (do_pop_s) begin
            sp_r <= sp_r - SP_W'(1);
        end
    end

    // Top-of-stack read, forced to zero when empty so no stale data leaks out
    always_comb begin
        top = {WIDTH{1'b0}};
        if (empty_s) begin
            top = {WIDTH{1'b0}};
        end else begin
            top = mem_r[rd_idx_s];
        end
    end

    assign sp    = sp_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/cs_microsequencer.sv
// -----------------------------------------------------------------------------
// cs_microsequencer
// Selects the next control-store address every cycle from increment, jump,
// opcode dispatch, PSR/IR conditional branch, micro-call/return or memory wait.
// Ports:
//   CS_SEQ_CLOCK_50         in   system clock
//   CS_SEQ_RESET_InLow      in   synchronous reset, active-low
//   CS_SEQ_OP_InBUS         in   4      sequencing op (MIR COND field)
//   CS_SEQ_JUMP_ADDR_InBUS  in   ADDR_W jump / call target
//   CS_SEQ_IR_InBUS         in   32     instruction register
//   CS_SEQ_FLAGS_InBUS      in   4      ALU flags {N,Z,V,C}
//   CS_SEQ_SETCC_In         in   1      load PSR from FLAGS on retirement
//   CS_SEQ_ACK_In           in   1      memory acknowledge (WAIT only)
//   CS_SEQ_ADDRESS_OutBUS   out  ADDR_W registered uPC
//   CS_SEQ_PSR_OutBUS       out  4      registered PSR {N,Z,V,C}
//   CS_SEQ_STALL_Out        out  1      combinational WAIT-without-ACK
//   CS_SEQ_SP_OutBUS        out         return-stack occupancy
//   CS_SEQ_ERROR_Out        out  1      sticky stack overflow/underflow
// ADDR_W must be at least 11 so the dispatch address fits; STACK_DEPTH >= 1.
// -----------------------------------------------------------------------------
module cs_microsequencer
    import cs_seq_pkg::*;
#(
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned STACK_DEPTH  = 4,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                               CS_SEQ_CLOCK_50,
    input  logic                               CS_SEQ_RESET_InLow,
    input  logic [3:0]                         CS_SEQ_OP_InBUS,
    input  logic [ADDR_W-1:0]                  CS_SEQ_JUMP_ADDR_InBUS,
    input  logic [31:0]                        CS_SEQ_IR_InBUS,
    input  logic [3:0]                         CS_SEQ_FLAGS_InBUS,
    input  logic                               CS_SEQ_SETCC_In,
    input  logic                               CS_SEQ_ACK_In,
    output logic [ADDR_W-1:0]                  CS_SEQ_ADDRESS_OutBUS,
    output logic [3:0]                         CS_SEQ_PSR_OutBUS,
    output logic                               CS_SEQ_STALL_Out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   CS_SEQ_SP_OutBUS,
    output logic                               CS_SEQ_ERROR_Out
);

    localparam int unsigned SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_VECTOR);

    logic [ADDR_W-1:0] upc_r;
    logic [3:0]        psr_r;
    logic              error_r;

    logic [ADDR_W-1:0] inc_addr_s;
    logic [ADDR_W-1:0] dispatch_s;
    logic [ADDR_W-1:0] next_addr_s;
    logic              stall_s;
    logic              retire_s;
    logic              push_req_s;
    logic              pop_req_s;
    logic              err_set_s;

    logic [ADDR_W-1:0] stk_top_s;
    logic [SP_W-1:0]   stk_sp_s;
    logic              stk_full_s;
    logic              stk_empty_s;

    // Wraps naturally modulo 2^ADDR_W
    assign inc_addr_s = upc_r + ADDR_W'(1);
    assign dispatch_s = ADDR_W'(dispatch_addr(CS_SEQ_IR_InBUS));

    // Reset overrides the stall so the reset edge always takes effect
    assign stall_s  = CS_SEQ_RESET_InLow & (CS_SEQ_OP_InBUS == OP_WAIT) & ~CS_SEQ_ACK_In;
    assign retire_s = ~stall_s;

    // Next-address mux and stack/error requests; branches read the registered
    // PSR so a SETCC in the same microinstruction cannot affect its own branch
    always_comb begin
        next_addr_s = inc_addr_s;
        push_req_s  = 1'b0;
        pop_req_s   = 1'b0;
        err_set_s   = 1'b0;
        case (CS_SEQ_OP_InBUS)
            OP_NEXT:   next_addr_s = inc_addr_s;
            OP_BRN:    next_addr_s = psr_r[PSR_N] ? CS_SEQ_JUMP_ADDR_InBUS : inc_addr_s;
            OP_BRZ:    next_addr_s = psr_r[PSR_Z] ? CS_SEQ_JUMP_ADDR_InBUS : inc_addr_s;
            OP_BRV:    next_addr_s = psr_r[PSR_V] ? CS_SEQ_JUMP_ADDR_InBUS : inc_addr_s;
            OP_BRC:    next_addr_s = psr_r[PSR_C] ? CS_SEQ_JUMP_ADDR_InBUS : inc_addr_s;
            OP_BR13:   next_addr_s = CS_SEQ_IR_InBUS[13] ? CS_SEQ_JUMP_ADDR_InBUS : inc_addr_s;
            OP_JUMP:   next_addr_s = CS_SEQ_JUMP_ADDR_InBUS;
            OP_DECODE: next_addr_s = dispatch_s;
            OP_CALL: begin
                // Overflow degrades to NEXT so the microprogram keeps running
                if (stk_full_s) begin
                    next_addr_s = inc_addr_s;
                    err_set_s   = 1'b1;
                end else begin
                    next_addr_s = CS_SEQ_JUMP_ADDR_InBUS;
                    push_req_s  = 1'b1;
                end
            end
            OP_RET: begin
                // Underflow has no valid return point; restart at the reset vector
                if (stk_empty_s) begin
                    next_addr_s = RESET_ADDR;
                    err_set_s   = 1'b1;
                end else begin
                    next_addr_s = stk_top_s;
                    pop_req_s   = 1'b1;
                end
            end
            OP_WAIT:   next_addr_s = inc_addr_s;
            default:   next_addr_s = inc_addr_s;
        endcase
    end

    // Return stack; push/pop only take effect on a retiring edge
    cs_seq_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (CS_SEQ_CLOCK_50),
        .rst_n (CS_SEQ_RESET_InLow),
        .push  (push_req_s & retire_s),
        .pop   (pop_req_s & retire_s),
        .din   (inc_addr_s),
        .top   (stk_top_s),
        .sp    (stk_sp_s),
        .full  (stk_full_s),
        .empty (stk_empty_s)
    );

    // uPC, PSR and sticky error; everything holds while stalled
    always_ff @(posedge CS_SEQ_CLOCK_50) begin
        if (!CS_SEQ_RESET_InLow) begin
            upc_r   <= RESET_ADDR;
            psr_r   <= 4'b0000;
            error_r <= 1'b0;
        end else if (retire_s) begin
            upc_r <= next_addr_s;
            if (CS_SEQ_SETCC_In) begin
                psr_r <= CS_SEQ_FLAGS_InBUS;
            end
            if (err_set_s) begin
                error_r <= 1'b1;
            end
        end
    end

    assign CS_SEQ_ADDRESS_OutBUS = upc_r;
    assign CS_SEQ_PSR_OutBUS     = psr_r;
    assign CS_SEQ_STALL_Out      = stall_s;
    assign CS_SEQ_SP_OutBUS      = stk_sp_s;
    assign CS_SEQ_ERROR_Out      = error_r;

endmodule

// File: tb/tb_cs_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_cs_microsequencer
// Directed vector table with hand-derived expectations, followed by random
// stimulus checked against a queue-based behavioural model.
// -----------------------------------------------------------------------------
module tb_cs_microsequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  op;
    logic [10:0] jmp;
    logic [31:0] ir;
    logic [3:0]  flags;
    logic        setcc;
    logic        ack;
    logic [10:0] addr;
    logic [3:0]  psr;
    logic        stall;
    logic [2:0]  sp;
    logic        err;

    always #5 clk = ~clk;

    cs_microsequencer #(
        .ADDR_W       (11),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (0)
    ) dut (
        .CS_SEQ_CLOCK_50        (clk),
        .CS_SEQ_RESET_InLow     (rst_n),
        .CS_SEQ_OP_InBUS        (op),
        .CS_SEQ_JUMP_ADDR_InBUS (jmp),
        .CS_SEQ_IR_InBUS        (ir),
        .CS_SEQ_FLAGS_InBUS     (flags),
        .CS_SEQ_SETCC_In        (setcc),
        .CS_SEQ_ACK_In          (ack),
        .CS_SEQ_ADDRESS_OutBUS  (addr),
        .CS_SEQ_PSR_OutBUS      (psr),
        .CS_SEQ_STALL_Out       (stall),
        .CS_SEQ_SP_OutBUS       (sp),
        .CS_SEQ_ERROR_Out       (err)
    );

    typedef struct {
        logic [3:0]  op;
        logic [10:0] jmp;
        logic [31:0] ir;
        logic [3:0]  flags;
        logic        setcc;
        logic        ack;
        logic        rstn;
        logic [10:0] e_addr;
        logic [3:0]  e_psr;
        logic [2:0]  e_sp;
        logic        e_err;
        logic        e_stall;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Behavioural model state
    int unsigned m_upc;
    logic [3:0]  m_psr;
    int unsigned m_stk[$];
    bit          m_err;

    function automatic vec_t mk(input logic [3:0] o, input logic [10:0] j, input logic [31:0] i,
                                input logic [3:0] f, input logic sc, input logic a, input logic rn,
                                input logic [10:0] ea, input logic [3:0] ep, input logic [2:0] es,
                                input logic ee, input logic est);
        vec_t v;
        v.op = o; v.jmp = j; v.ir = i; v.flags = f; v.setcc = sc; v.ack = a; v.rstn = rn;
        v.e_addr = ea; v.e_psr = ep; v.e_sp = es; v.e_err = ee; v.e_stall = est;
        return v;
    endfunction

    // Next uPC from the instruction-level rules, with a 2K address space
    task automatic model_step(input vec_t v);
        int unsigned nxt;
        int unsigned inc;
        if (!v.rstn) begin
            m_upc = 0; m_psr = 4'b0000; m_err = 1'b0; m_stk.delete();
        end else if (v.op == 4'd10 && !v.ack) begin
            // stalled: nothing changes
        end else begin
            inc = (m_upc + 1) % 2048;
            nxt = inc;
            case (v.op)
                4'd1, 4'd2, 4'd3, 4'd4: if (m_psr[4 - int'(v.op)]) nxt = v.jmp;
                4'd5: if (v.ir[13]) nxt = v.jmp;
                4'd6: nxt = v.jmp;
                4'd7: nxt = 1024 + int'(v.ir[31:30]) * 256 + int'(v.ir[24:19]) * 4;
                4'd8: begin
                    if (m_stk.size() >= 4) m_err = 1'b1;
                    else begin m_stk.push_back(inc); nxt = v.jmp; end
                end
                4'd9: begin
                    if (m_stk.size() == 0) begin nxt = 0; m_err = 1'b1; end
                    else nxt = m_stk.pop_back();
                end
                default: ;
            endcase
            if (v.setcc) m_psr = v.flags;
            m_upc = nxt;
        end
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx, input bit use_model);
        logic        x_stall;
        logic [10:0] x_addr;
        logic [3:0]  x_psr;
        logic [2:0]  x_sp;
        logic        x_err;
        @(negedge clk);
        op = v.op; jmp = v.jmp; ir = v.ir; flags = v.flags;
        setcc = v.setcc; ack = v.ack; rst_n = v.rstn;
        #1;
        x_stall = use_model ? (v.rstn && v.op == 4'd10 && !v.ack) : v.e_stall;
        chk("stall", idx, {31'd0, stall}, {31'd0, x_stall});
        @(posedge clk);
        model_step(v);
        #1;
        if (use_model) begin
            x_addr = 11'(m_upc); x_psr = m_psr; x_sp = 3'(m_stk.size()); x_err = m_err;
        end else begin
            x_addr = v.e_addr; x_psr = v.e_psr; x_sp = v.e_sp; x_err = v.e_err;
        end
        chk("addr", idx, {21'd0, addr}, {21'd0, x_addr});
        chk("psr", idx, {28'd0, psr}, {28'd0, x_psr});
        chk("sp", idx, {29'd0, sp}, {29'd0, x_sp});
        chk("error", idx, {31'd0, err}, {31'd0, x_err});
        n_vec++;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; op = 4'd0; jmp = 11'd0; ir = 32'd0; flags = 4'd0; setcc = 1'b0; ack = 1'b0;

        //               op    jmp      ir             flg    sc    ack   rn    addr     psr    sp    err   stall
        // reset, forced-low stall, increment and wrap
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd10,11'h000, 32'h0,         4'hF, 1'b1, 1'b0, 1'b0, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h001, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h002, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h003, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd6, 11'h7FF, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h7FF, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0));
        // conditional branches see the old PSR
        tbl.push_back(mk(4'd6, 11'h020, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h020, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd2, 11'h100, 32'h0,         4'h4, 1'b1, 1'b0, 1'b1, 11'h021, 4'h4, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd2, 11'h100, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h100, 4'h4, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd1, 11'h300, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h101, 4'h4, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd4, 11'h300, 32'h0,         4'h1, 1'b1, 1'b0, 1'b1, 11'h102, 4'h1, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd4, 11'h300, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h300, 4'h1, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd3, 11'h010, 32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 11'h301, 4'h1, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd5, 11'h050, 32'h0000_2000, 4'h0, 1'b0, 1'b0, 1'b1, 11'h050, 4'h1, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd5, 11'h070, 32'hFFFF_DFFF, 4'h0, 1'b0, 1'b0, 1'b1, 11'h051, 4'h1, 3'd0, 1'b0, 1'b0));
        // dispatch
        tbl.push_back(mk(4'd7, 11'h000, 32'h8080_0000, 4'h0, 1'b0, 1'b0, 1'b1, 11'h640, 4'h1, 3'd0, 1'b0, 1'b0));
        // nested calls and returns
        tbl.push_back(mk(4'd6, 11'h010, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h010, 4'h1, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd8, 11'h200, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h200, 4'h1, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(4'd8, 11'h300, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h300, 4'h1, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(4'd9, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h201, 4'h1, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(4'd9, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h011, 4'h1, 3'd0, 1'b0, 1'b0));
        // overflow on the 5th call, then sticky error
        tbl.push_back(mk(4'd8, 11'h020, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h020, 4'h1, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(4'd8, 11'h030, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h030, 4'h1, 3'd2, 1'b0, 1'b0));
        tbl.push_back(mk(4'd8, 11'h040, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h040, 4'h1, 3'd3, 1'b0, 1'b0));
        tbl.push_back(mk(4'd8, 11'h060, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h060, 4'h1, 3'd4, 1'b0, 1'b0));
        tbl.push_back(mk(4'd8, 11'h070, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h061, 4'h1, 3'd4, 1'b1, 1'b0));
        tbl.push_back(mk(4'd9, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h041, 4'h1, 3'd3, 1'b1, 1'b0));
        // reset clears error; underflow on RET
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h001, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd9, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h000, 4'h0, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0));
        // WAIT handshake: three stalled cycles with SETCC ignored
        tbl.push_back(mk(4'd6, 11'h050, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h050, 4'h0, 3'd0, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(4'd10, 11'h000, 32'h0,    4'hF, 1'b1, 1'b0, 1'b1, 11'h050, 4'h0, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(4'd10,11'h000, 32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 11'h051, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h052, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd10,11'h000, 32'h0,         4'hA, 1'b1, 1'b1, 1'b1, 11'h053, 4'hA, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd6, 11'h050, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h050, 4'hA, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd10,11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h050, 4'hA, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(4'd10,11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0));
        // reset mid-subroutine, reserved op, CALL then RET, push of a wrapped return
        tbl.push_back(mk(4'd8, 11'h100, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h100, 4'h0, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(4'd0, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b0, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd12,11'h3AB, 32'h0,         4'h0, 1'b0, 1'b1, 1'b1, 11'h001, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd8, 11'h200, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h200, 4'h0, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(4'd9, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h002, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd6, 11'h7FF, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h7FF, 4'h0, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(4'd8, 11'h123, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h123, 4'h0, 3'd1, 1'b0, 1'b0));
        tbl.push_back(mk(4'd9, 11'h000, 32'h0,         4'h0, 1'b0, 1'b0, 1'b1, 11'h000, 4'h0, 3'd0, 1'b0, 1'b0));

        foreach (tbl[i]) apply(tbl[i], i, 1'b0);

        // Random phase: start from reset, bias toward stack and wait ops
        v = mk(4'd0, 11'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 11'h0, 4'h0, 3'd0, 1'b0, 1'b0);
        apply(v, 1000, 1'b1);
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 15)      v.op = 4'd8;
            else if (r < 30) v.op = 4'd9;
            else if (r < 40) v.op = 4'd10;
            else             v.op = 4'($urandom_range(0, 15));
            v.jmp   = 11'($urandom);
            v.ir    = $urandom;
            v.flags = 4'($urandom);
            v.setcc = 1'($urandom);
            v.ack   = ($urandom_range(0, 2) != 0);
            v.rstn  = ($urandom_range(0, 99) != 0);
            apply(v, 2000 + n, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
